// File: rtl/vector_lane_dispatcher.sv
// vector_lane_dispatcher: sequences one vector instruction across the ALU lanes and assembles vd.
module vector_lane_dispatcher #(
  parameter int LEN = 32,
  parameter int VECTOR_SIZE = 8,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int LANE_SIZE = 2,
  parameter int LANE_INDEX_SIZE = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ENTRY_INDEX_SIZE:0]     vl,
  input  logic [VECTOR_SIZE*LEN-1:0]    vs1_data,
  input  logic [VECTOR_SIZE*LEN-1:0]    vs2_data,
  input  logic [VECTOR_SIZE*LEN-1:0]    vd_old_data,
  input  logic [VECTOR_SIZE-1:0]        mask_bits,
  input  logic                          mask_enable,
  input  logic [LEN-1:0]                imm,
  input  logic [LEN-1:0]                rs,
  input  logic [2:0]                    alu_signal,
  input  logic [1:0]                    vec_operand_type,
  input  logic [5:0]                    opcode,
  output logic [LANE_SIZE*LEN-1:0]      lane_vs1,
  output logic [LANE_SIZE*LEN-1:0]      lane_vs2,
  output logic [LANE_SIZE*LEN-1:0]      lane_mask,
  output logic [LANE_SIZE*LEN-1:0]      lane_imm,
  output logic [LANE_SIZE*LEN-1:0]      lane_rs,
  output logic [2:0]                    lane_alu_signal,
  output logic [1:0]                    lane_vec_operand_type,
  output logic [5:0]                    lane_opcode,
  input  logic [LANE_SIZE*LEN-1:0]      lane_result,
  output logic                          busy,
  output logic                          done,
  output logic [VECTOR_SIZE*LEN-1:0]    vd_data,
  output logic [VECTOR_SIZE-1:0]        vd_elem_written
);
  localparam int EW = ENTRY_INDEX_SIZE + 1;
  localparam int GW = ENTRY_INDEX_SIZE - LANE_INDEX_SIZE + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state, state_n;
  logic [GW-1:0] g;
  logic [EW-1:0] vl_q;
  logic [VECTOR_SIZE*LEN-1:0] vs1_q, vs2_q;
  logic [VECTOR_SIZE-1:0] mask_q;
  logic mask_en_q;
  logic [LEN-1:0] imm_q, rs_q;
  logic [2:0] alu_q;
  logic [1:0] type_q;
  logic [5:0] opcode_q;
  logic [LANE_SIZE-1:0][EW-1:0] e;
  logic [LANE_SIZE-1:0] in_vl, act;
  logic issue, last;
  assign issue = state == ISSUE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign last = (int'(g) + 1) * LANE_SIZE >= int'(vl_q);
  assign lane_alu_signal = issue ? alu_q : '0;
  assign lane_vec_operand_type = issue ? type_q : '0;
  assign lane_opcode = issue ? opcode_q : '0;
  // Tail lanes get all-zero operands; masked-off lanes still see operands but a zero lane_mask.
  for (genvar i = 0; i < LANE_SIZE; i++) begin : g_lane
    assign e[i] = EW'(int'(g) * LANE_SIZE + i);
    assign in_vl[i] = issue && (e[i] < vl_q);
    assign act[i] = in_vl[i] && (!mask_en_q || mask_q[e[i][ENTRY_INDEX_SIZE-1:0]]);
    assign lane_vs1[i*LEN +: LEN] = in_vl[i] ? vs1_q[e[i][ENTRY_INDEX_SIZE-1:0]*LEN +: LEN] : '0;
    assign lane_vs2[i*LEN +: LEN] = in_vl[i] ? vs2_q[e[i][ENTRY_INDEX_SIZE-1:0]*LEN +: LEN] : '0;
    assign lane_imm[i*LEN +: LEN] = in_vl[i] ? imm_q : '0;
    assign lane_rs[i*LEN +: LEN] = in_vl[i] ? rs_q : '0;
    assign lane_mask[i*LEN +: LEN] = {LEN{act[i]}};
  end
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = start ? ((vl == '0) ? DONE : ISSUE) : IDLE;
    else if (state == ISSUE) state_n = last ? DONE : ISSUE;
    else state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g <= '0;
      vl_q <= '0;
      vs1_q <= '0;
      vs2_q <= '0;
      mask_q <= '0;
      mask_en_q <= 1'b0;
      imm_q <= '0;
      rs_q <= '0;
      alu_q <= '0;
      type_q <= '0;
      opcode_q <= '0;
      vd_data <= '0;
      vd_elem_written <= '0;
    end else if (state == IDLE && start) begin
      g <= '0;
      vl_q <= (vl > EW'(VECTOR_SIZE)) ? EW'(VECTOR_SIZE) : vl;
      vs1_q <= vs1_data;
      vs2_q <= vs2_data;
      mask_q <= mask_bits;
      mask_en_q <= mask_enable;
      imm_q <= imm;
      rs_q <= rs;
      alu_q <= alu_signal;
      type_q <= vec_operand_type;
      opcode_q <= opcode;
      vd_data <= vd_old_data;
      vd_elem_written <= '0;
    end else if (issue) begin
      g <= g + 1'b1;
      for (int i = 0; i < LANE_SIZE; i++)
        if (act[i]) begin
          vd_data[e[i][ENTRY_INDEX_SIZE-1:0]*LEN +: LEN] <= lane_result[i*LEN +: LEN];
          vd_elem_written[e[i][ENTRY_INDEX_SIZE-1:0]] <= 1'b1;
        end
    end
  end
endmodule

// File: tb/tb_vector_lane_dispatcher.sv
// tb_vector_lane_dispatcher: directed vectors with a done-triggered scoreboard monitor.
module tb_vector_lane_dispatcher;
  localparam int LEN = 32;
  localparam int VS = 8;
  localparam int LS = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [3:0] vl = '0;
  logic [VS*LEN-1:0] vs1_data = '0, vs2_data = '0, vd_old_data = '0;
  logic [VS-1:0] mask_bits = '0;
  logic mask_enable = 1'b0;
  logic [LEN-1:0] imm = '0, rs = '0;
  logic [2:0] alu_signal = '0;
  logic [1:0] vec_operand_type = '0;
  logic [5:0] opcode = '0;
  logic [LS*LEN-1:0] lane_vs1, lane_vs2, lane_mask, lane_imm, lane_rs, lane_result;
  logic [2:0] lane_alu_signal;
  logic [1:0] lane_vec_operand_type;
  logic [5:0] lane_opcode;
  logic busy, done;
  logic [VS*LEN-1:0] vd_data;
  logic [VS-1:0] vd_elem_written;
  int n_vec = 0, n_err = 0;
  logic [VS*LEN-1:0] exp_vd[$];
  logic [VS-1:0] exp_wr[$];
  logic [LS*LEN-1:0] s_vs1[0:20], s_vs2[0:20], s_mask[0:20], s_imm[0:20], s_rs[0:20];
  logic [10:0] s_ctl[0:20];

  vector_lane_dispatcher dut (
    .clk(clk), .rst(rst), .start(start), .vl(vl),
    .vs1_data(vs1_data), .vs2_data(vs2_data), .vd_old_data(vd_old_data),
    .mask_bits(mask_bits), .mask_enable(mask_enable), .imm(imm), .rs(rs),
    .alu_signal(alu_signal), .vec_operand_type(vec_operand_type), .opcode(opcode),
    .lane_vs1(lane_vs1), .lane_vs2(lane_vs2), .lane_mask(lane_mask),
    .lane_imm(lane_imm), .lane_rs(lane_rs), .lane_alu_signal(lane_alu_signal),
    .lane_vec_operand_type(lane_vec_operand_type), .lane_opcode(lane_opcode),
    .lane_result(lane_result), .busy(busy), .done(done),
    .vd_data(vd_data), .vd_elem_written(vd_elem_written)
  );

  for (genvar i = 0; i < LS; i++) begin : g_alu
    assign lane_result[i*LEN +: LEN] = lane_vs1[i*LEN +: LEN] + lane_vs2[i*LEN +: LEN];
  end

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [VS*LEN-1:0] act, input logic [VS*LEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (done === 1'b1) begin
      if (exp_vd.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        check("vd_data", vd_data, exp_vd.pop_front());
        check("vd_elem_written", {248'b0, vd_elem_written}, {248'b0, exp_wr.pop_front()});
      end
    end

  task automatic set_ops();
    for (int i = 0; i < VS; i++) begin
      vs1_data[i*LEN +: LEN] = i;
      vs2_data[i*LEN +: LEN] = 10 * i;
      vd_old_data[i*LEN +: LEN] = 32'hDEAD0000 + i;
    end
    imm = 32'h1234;
    rs = 32'h5678;
    alu_signal = 3'd5;
    vec_operand_type = 2'd2;
    opcode = 6'h15;
  endtask

  function automatic logic [VS*LEN-1:0] model(input logic [3:0] v, input logic men, input logic [VS-1:0] m);
    logic [VS*LEN-1:0] r;
    int veff;
    veff = (v > 8) ? 8 : int'(v);
    for (int i = 0; i < VS; i++)
      r[i*LEN +: LEN] = (i < veff && (!men || m[i])) ? vs1_data[i*LEN +: LEN] + vs2_data[i*LEN +: LEN]
                                                    : vd_old_data[i*LEN +: LEN];
    return r;
  endfunction

  task automatic scramble();
    for (int i = 0; i < VS; i++) begin
      vs1_data[i*LEN +: LEN] = $urandom;
      vs2_data[i*LEN +: LEN] = $urandom;
      vd_old_data[i*LEN +: LEN] = $urandom;
    end
    imm = $urandom;
    rs = $urandom;
    alu_signal = 3'($urandom);
    vec_operand_type = 2'($urandom);
    opcode = 6'($urandom);
    mask_bits = ~mask_bits;
    mask_enable = ~mask_enable;
    vl = 4'($urandom);
  endtask

  task automatic run(input logic [3:0] v, input logic men, input logic [VS-1:0] m,
                     input logic [VS-1:0] wr, input int exp_lat, input int busy_at);
    int lat;
    set_ops();
    vl = v;
    mask_enable = men;
    mask_bits = m;
    exp_vd.push_back(model(v, men, m));
    exp_wr.push_back(wr);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    scramble();
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      s_vs1[lat] = lane_vs1;
      s_vs2[lat] = lane_vs2;
      s_mask[lat] = lane_mask;
      s_imm[lat] = lane_imm;
      s_rs[lat] = lane_rs;
      s_ctl[lat] = {lane_alu_signal, lane_vec_operand_type, lane_opcode};
      if (busy_at != 0 && lat == busy_at) start = 1'b1;
      if (busy_at != 0 && lat == busy_at + 1) start = 1'b0;
      if (done) break;
    end
    check("latency", lat, exp_lat);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_in_done_ignored", busy, 0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check("reset_busy_done", {busy, done}, 0);
    check("reset_vd_data", vd_data, 0);
    check("reset_vd_elem_written", vd_elem_written, 0);
    check("reset_lanes", {lane_vs1, lane_vs2, lane_mask, lane_imm}, 0);
    check("reset_lane_rs_ctl", {lane_rs, lane_alu_signal, lane_vec_operand_type, lane_opcode}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    run(4'd8, 1'b0, 8'h00, 8'hFF, 5, 0);
    check("full_g0_vs1", s_vs1[1], {32'd1, 32'd0});
    check("full_g0_vs2", s_vs2[1], {32'd10, 32'd0});
    check("full_g0_mask", s_mask[1], {64{1'b1}});
    check("full_g0_imm_rs", {s_imm[1], s_rs[1]}, {32'h1234, 32'h1234, 32'h5678, 32'h5678});
    check("full_ctl", s_ctl[1], {3'd5, 2'd2, 6'h15});
    check("full_g3_vs1", s_vs1[4], {32'd7, 32'd6});
    check("full_lanes_in_done", s_vs1[5] | s_mask[5] | s_imm[5], 0);
    check("full_elem3", vd_data[3*LEN +: LEN], 32'd33);
    check("full_elem7", vd_data[7*LEN +: LEN], 32'd77);

    run(4'd3, 1'b0, 8'h00, 8'h07, 3, 0);
    check("tail_g1_vs1", s_vs1[2], {32'd0, 32'd2});
    check("tail_g1_mask", s_mask[2], {32'd0, 32'hFFFFFFFF});
    check("tail_g1_imm", s_imm[2], {32'd0, 32'h1234});
    check("tail_elem2", vd_data[2*LEN +: LEN], 32'd22);
    check("tail_elem5", vd_data[5*LEN +: LEN], 32'hDEAD0005);

    run(4'd8, 1'b1, 8'hAA, 8'hAA, 5, 0);
    check("mask_g0_mask", s_mask[1], {32'hFFFFFFFF, 32'd0});
    check("mask_g0_vs1", s_vs1[1], {32'd1, 32'd0});
    check("mask_g2_mask", s_mask[3], {32'hFFFFFFFF, 32'd0});
    check("mask_elem0", vd_data[0*LEN +: LEN], 32'hDEAD0000);
    check("mask_elem1", vd_data[1*LEN +: LEN], 32'd11);

    run(4'd0, 1'b0, 8'h00, 8'h00, 1, 0);
    check("vl0_elem4", vd_data[4*LEN +: LEN], 32'hDEAD0004);

    run(4'd12, 1'b0, 8'h00, 8'hFF, 5, 0);
    check("vl12_elem7", vd_data[7*LEN +: LEN], 32'd77);

    run(4'd8, 1'b0, 8'h00, 8'hFF, 5, 2);
    check("busy_start_elem6", vd_data[6*LEN +: LEN], 32'd66);

    set_ops();
    vl = 4'd8;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_busy_done", {busy, done}, 0);
    check("abort_vd", {vd_data, vd_elem_written}, 0);
    check("abort_lanes", {lane_vs1, lane_vs2, lane_mask, lane_imm, lane_rs}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_idle", busy, 0);
    @(posedge clk);
    #1;

    run(4'd5, 1'b0, 8'h00, 8'h1F, 4, 0);
    check("after_abort_elem4", vd_data[4*LEN +: LEN], 32'd44);
    check("after_abort_elem5", vd_data[5*LEN +: LEN], 32'hDEAD0005);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_vd.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
